writeback_stage: RTL
====================

# writeback_stage

Final pipeline stage, directly downstream of the memory stage. It commits the memory stage's result bundle to architectural state: the scalar register file, the vector register file and the condition-code register. It also keeps the per-register pending-write scoreboard that the decode stage uses for dependency stalls, and counts retired instructions. Decode reads operands through its combinational read ports, which bypass a commit in the same cycle.

## Interface
- NUM_REGS, 16, scalar register count (index width 4)
- REG_WIDTH, 16, scalar register width
- NUM_VREGS, 64, vector register count (index width 6)
- VREG_WIDTH, 64, vector register width
- SB_CNT_WIDTH, 2, width of each pending-write counter
---
- I_CLOCK  in  1  single clock; all state updates on its falling edge, as in the rest of the pipeline
- I_RESET  in  1  synchronous, active-high reset
- I_MEM_Valid  in  1  bundle from memory stage is valid
- I_RegWEn / I_VRegWEn / I_CCWEn  in  1 each  write enables from memory stage
- I_DestRegIdx  in  4  scalar destination index
- I_DestVRegIdx  in  6  vector destination index
- I_DestValue  in  REG_WIDTH  scalar result
- I_VecDestValue  in  VREG_WIDTH  vector result
- I_CCValue  in  3  condition codes {N,Z,P}
- I_IssueRegValid  in  1  decode issued an instruction that writes a scalar register
- I_IssueRegIdx  in  4  that register
- I_RdIdx1, I_RdIdx2  in  4 each  scalar read addresses
- I_VRdIdx  in  6  vector read address
- O_RdData1, O_RdData2  out  REG_WIDTH  scalar read data (combinational)
- O_VRdData  out  VREG_WIDTH  vector read data (combinational)
- O_CC  out  3  architectural condition codes (combinational, with bypass)
- O_RegBusy  out  NUM_REGS  bit i set when counter i is nonzero
- O_SBFull  out  NUM_REGS  bit i set when counter i is saturated
- O_RetireCount  out  16  number of committed valid bundles

## Operation
- Commit: `commit = I_MEM_Valid & ~I_RESET`.
  - On commit with I_RegWEn: RF[I_DestRegIdx] <= I_DestValue.
  - On commit with I_VRegWEn: VRF[I_DestVRegIdx] <= I_VecDestValue.
  - On commit with I_CCWEn: CC <= I_CCValue.
  - Enables are ignored when I_MEM_Valid=0.
- Every register is writable; there is no hardwired zero register.
- Read bypass: a read whose index equals the index being committed this cycle with its enable set returns the incoming value. Otherwise it returns the stored value. Same rule for O_CC.
- Scoreboard: one SB_CNT_WIDTH-bit counter per scalar register.
  - inc = I_IssueRegValid for I_IssueRegIdx.
  - dec = commit & I_RegWEn for I_DestRegIdx.
  - inc and dec on the same index in one cycle: counter unchanged.
  - inc on a saturated counter (3): ignored. Decode must stall on O_SBFull.
  - dec on a zero counter: ignored.
- O_RetireCount increments by 1 per commit and wraps 0xFFFF→0x0000.

## Timing
- Write latency: the value is visible in stored state after the falling edge on which commit is high. Because of the bypass, it is also visible on the read ports during that same cycle.
- O_RegBusy and O_SBFull are registered-derived and update one edge after inc/dec.
- Reset (I_RESET=1 at a falling edge):
  - all RF, VRF, CC (3'b000), scoreboard counters and O_RetireCount go to 0; O_RegBusy=0, O_SBFull=0.
  - A bundle presented in a reset cycle is dropped: no write, no dec, no count.
  - Reset mid-operation discards all pending scoreboard state.
- Read ports hold no state; their output is a function of current indices, stored state and the current commit.

## Structure
- Shared package (global_def.h): REG_WIDTH, VREG_WIDTH, VREG_ID_WIDTH, the NUM_REGS/NUM_VREGS sizes and the CC bit encoding {N,Z,P}.
- One sub-module, `pending_write_scoreboard`, holds the counter array, the inc/dec arbitration and the busy/full flag generation. The register files and bypass muxes stay in the top module.

## Test plan
- Reset: assert I_RESET with commit of R3=0x1234 -> R3 reads 0x0000, O_RetireCount=0, O_RegBusy=0.
- Commit and bypass: commit R5=0xBEEF with I_RdIdx1=5 -> O_RdData1=0xBEEF in the same cycle and after the edge. Then commit with I_MEM_Valid=0 and R5=0x1111 -> R5 stays 0xBEEF.
- Vector and CC: commit V42=64'h0123456789ABCDEF with CC=3'b010 -> O_VRdData matches for I_VRdIdx=42, O_CC=3'b010, scalar RF unchanged.
- Scoreboard saturation: issue R7 four times -> counter reads 3, O_SBFull[7]=1, fourth inc ignored. Three commits to R7 -> O_RegBusy[7]=0.
- Simultaneous inc/dec: with counter R2=1, issue R2 and commit R2 in the same cycle -> counter stays 1, O_RegBusy[2]=1. Dec on R9 with counter 0 -> stays 0.
- Retire wrap: preload O_RetireCount to 0xFFFF with 65535 commits, then commit once more -> 0x0000.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared sizes and types for the writeback stage and its scoreboard.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package writeback_stage_pkg;

   localparam int NUM_REGS      = 16;
   localparam int REG_IDX_WIDTH = $clog2(NUM_REGS);
   localparam int REG_WIDTH     = 16;
   localparam int NUM_VREGS     = 64;
   localparam int VREG_ID_WIDTH = $clog2(NUM_VREGS);
   localparam int VREG_WIDTH    = 64;
   localparam int SB_CNT_WIDTH  = 2;
   localparam int CC_WIDTH      = 3;
   localparam int RETIRE_WIDTH  = 16;

   // Condition-code register layout, MSB first: {N,Z,P}
   typedef struct packed {
      logic n;
      logic z;
      logic p;
   } cc_t;

   typedef logic [SB_CNT_WIDTH-1:0] sb_cnt_t;

   localparam sb_cnt_t SB_CNT_MAX = '1;
   localparam sb_cnt_t SB_CNT_ONE = sb_cnt_t'(1);

endpackage

// File: rtl/pending_write_scoreboard.sv
// Per-register saturating count of in-flight scalar writes (issue inc, commit dec).
// Latency: counters and flags update on the falling edge after an inc/dec.
// Backpressure: none; inc on a full counter is dropped, decode must stall on full_o.
module pending_write_scoreboard
   import writeback_stage_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     inc_vld_i,
   input  logic [REG_IDX_WIDTH-1:0] inc_idx_i,
   input  logic                     dec_vld_i,
   input  logic [REG_IDX_WIDTH-1:0] dec_idx_i,
   output logic [NUM_REGS-1:0]      busy_o,
   output logic [NUM_REGS-1:0]      full_o
);

   sb_cnt_t cnt_q [NUM_REGS];
   sb_cnt_t cnt_d [NUM_REGS];

   // Next count: an inc and dec on the same entry cancel; saturate at both ends
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc_vld_i && (inc_idx_i == REG_IDX_WIDTH'(i)) &&
             !(dec_vld_i && (dec_idx_i == REG_IDX_WIDTH'(i)))) begin
            if (cnt_q[i] != SB_CNT_MAX) begin
               cnt_d[i] = cnt_q[i] + SB_CNT_ONE;
            end
         end else if (dec_vld_i && (dec_idx_i == REG_IDX_WIDTH'(i)) &&
                      !(inc_vld_i && (inc_idx_i == REG_IDX_WIDTH'(i)))) begin
            if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - SB_CNT_ONE;
            end
         end
      end
   end

   // Counter state; reset discards every outstanding write
   always_ff @(negedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flags derived from stored counts only, so they lag inc/dec by one edge
   always_comb begin
      busy_o = '0;
      full_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_o[i] = (cnt_q[i] != '0);
         full_o[i] = (cnt_q[i] == SB_CNT_MAX);
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Commits memory-stage results to scalar RF, vector RF and CC; bypassed read ports for decode.
// Latency: state written on the falling edge of the commit cycle; reads see it same cycle via bypass.
// Backpressure: none; a valid bundle is committed every cycle it is presented outside reset.
module writeback_stage
   import writeback_stage_pkg::*;
(
   input  logic                     I_CLOCK,
   input  logic                     I_RESET,
   input  logic                     I_MEM_Valid,
   input  logic                     I_RegWEn,
   input  logic                     I_VRegWEn,
   input  logic                     I_CCWEn,
   input  logic [REG_IDX_WIDTH-1:0] I_DestRegIdx,
   input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
   input  logic [REG_WIDTH-1:0]     I_DestValue,
   input  logic [VREG_WIDTH-1:0]    I_VecDestValue,
   input  logic [CC_WIDTH-1:0]      I_CCValue,
   input  logic                     I_IssueRegValid,
   input  logic [REG_IDX_WIDTH-1:0] I_IssueRegIdx,
   input  logic [REG_IDX_WIDTH-1:0] I_RdIdx1,
   input  logic [REG_IDX_WIDTH-1:0] I_RdIdx2,
   input  logic [VREG_ID_WIDTH-1:0] I_VRdIdx,
   output logic [REG_WIDTH-1:0]     O_RdData1,
   output logic [REG_WIDTH-1:0]     O_RdData2,
   output logic [VREG_WIDTH-1:0]    O_VRdData,
   output logic [CC_WIDTH-1:0]      O_CC,
   output logic [NUM_REGS-1:0]      O_RegBusy,
   output logic [NUM_REGS-1:0]      O_SBFull,
   output logic [RETIRE_WIDTH-1:0]  O_RetireCount
);

   logic [REG_WIDTH-1:0]    rf_q  [NUM_REGS];
   logic [VREG_WIDTH-1:0]   vrf_q [NUM_VREGS];
   cc_t                     cc_q, cc_d;
   logic [RETIRE_WIDTH-1:0] retire_q, retire_d;

   logic commit;
   logic rf_we;
   logic vrf_we;
   logic cc_we;

   // A bundle arriving during reset is dropped entirely
   assign commit = I_MEM_Valid & ~I_RESET;
   assign rf_we  = commit & I_RegWEn;
   assign vrf_we = commit & I_VRegWEn;
   assign cc_we  = commit & I_CCWEn;

   // Next CC and retire count
   always_comb begin
      cc_d     = cc_q;
      retire_d = retire_q;
      if (cc_we) begin
         cc_d = cc_t'(I_CCValue);
      end
      if (commit) begin
         retire_d = retire_q + RETIRE_WIDTH'(1);
      end
   end

   // Scalar register file write
   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (rf_we) begin
         rf_q[I_DestRegIdx] <= I_DestValue;
      end
   end

   // Vector register file write
   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         for (int i = 0; i < NUM_VREGS; i++) begin
            vrf_q[i] <= '0;
         end
      end else if (vrf_we) begin
         vrf_q[I_DestVRegIdx] <= I_VecDestValue;
      end
   end

   // Condition codes and retired-instruction counter (wraps naturally)
   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         cc_q     <= '0;
         retire_q <= '0;
      end else begin
         cc_q     <= cc_d;
         retire_q <= retire_d;
      end
   end

   // Read ports: forward the value being committed this cycle on an index match
   always_comb begin
      O_RdData1 = rf_q[I_RdIdx1];
      O_RdData2 = rf_q[I_RdIdx2];
      O_VRdData = vrf_q[I_VRdIdx];
      O_CC      = cc_q;
      if (rf_we && (I_RdIdx1 == I_DestRegIdx)) O_RdData1 = I_DestValue;
      if (rf_we && (I_RdIdx2 == I_DestRegIdx)) O_RdData2 = I_DestValue;
      if (vrf_we && (I_VRdIdx == I_DestVRegIdx)) O_VRdData = I_VecDestValue;
      if (cc_we) O_CC = I_CCValue;
   end

   assign O_RetireCount = retire_q;

   pending_write_scoreboard u_scoreboard (
      .clk_i     (I_CLOCK),
      .rst_i     (I_RESET),
      .inc_vld_i (I_IssueRegValid),
      .inc_idx_i (I_IssueRegIdx),
      .dec_vld_i (rf_we),
      .dec_idx_i (I_DestRegIdx),
      .busy_o    (O_RegBusy),
      .full_o    (O_SBFull)
   );

endmodule
